// File: rtl/shared_mem_arbiter.sv
// Arbiter that shares one single-port memory between NCORES cores, one transaction at a time.
// Optional ARB_FIXED_PRIO_EN: lowest-index request wins instead of round-robin.
module shared_mem_arbiter #(
    parameter int NCORES  = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic                     clk,
    input  logic                     resetARB,
    input  logic [NCORES-1:0]        req,
    input  logic [NCORES-1:0]        we,
    input  logic [NCORES*ADDR_W-1:0] addr,
    input  logic [NCORES*DATA_W-1:0] wdata,
    output logic [NCORES-1:0]        gnt,
    output logic [NCORES-1:0]        done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int LAT_W = $clog2(MEM_LAT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic                we_lat_q, we_lat_d;
    logic [ADDR_W-1:0]   addr_lat_q, addr_lat_d;
    logic [DATA_W-1:0]   wdata_lat_q, wdata_lat_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [NCORES-1:0]   gnt_q, gnt_d;
    logic [NCORES-1:0]   done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
`ifndef ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
`endif

    logic [IDX_W-1:0]    win_sel_s;
    logic                any_req_s;

    function automatic logic [NCORES-1:0] one_hot(input logic [IDX_W-1:0] idx);
        one_hot = {{(NCORES-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Winner selection; scanning downward lets the first candidate in priority order win.
    always_comb begin
        any_req_s = |req;
        win_sel_s = {IDX_W{1'b0}};
`ifdef ARB_FIXED_PRIO_EN
        for (int i = NCORES - 1; i >= 0; i--) begin
            win_sel_s = req[i] ? IDX_W'(i) : win_sel_s;
        end
`else
        for (int i = NCORES - 1; i >= 0; i--) begin
            int idx_v;
            idx_v = int'(rr_ptr_q) + i;
            idx_v = (idx_v >= NCORES) ? (idx_v - NCORES) : idx_v;
            win_sel_s = req[idx_v] ? IDX_W'(idx_v) : win_sel_s;
        end
`endif
    end

    // Transaction sequencer next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_lat_d    = we_lat_q;
        addr_lat_d  = addr_lat_q;
        wdata_lat_d = wdata_lat_q;
        lat_cnt_d   = lat_cnt_q;
        gnt_d       = gnt_q;
        done_d      = done_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifndef ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    win_d       = win_sel_s;
                    we_lat_d    = we[win_sel_s];
                    addr_lat_d  = addr[int'(win_sel_s)*ADDR_W +: ADDR_W];
                    wdata_lat_d = wdata[int'(win_sel_s)*DATA_W +: DATA_W];
                    gnt_d       = one_hot(win_sel_s);
                    busy_d      = 1'b1;
                    state_d     = S_ISSUE;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_ISSUE: begin
                mem_en_d    = 1'b1;
                mem_we_d    = we_lat_q;
                mem_addr_d  = addr_lat_q;
                mem_wdata_d = wdata_lat_q;
                // Counts every edge from the memory's sampling edge up to the data-valid edge.
                lat_cnt_d   = LAT_W'(MEM_LAT);
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                if (lat_cnt_q != {LAT_W{1'b0}}) begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                    state_d   = S_WAIT;
                end else begin
                    if (!we_lat_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    done_d  = one_hot(win_q);
                    gnt_d   = {NCORES{1'b0}};
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                done_d  = {NCORES{1'b0}};
                busy_d  = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
                rr_ptr_d = (win_q == IDX_W'(NCORES - 1)) ? {IDX_W{1'b0}} : (win_q + IDX_W'(1));
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge resetARB) begin
        if (resetARB) begin
            state_q     <= S_IDLE;
            win_q       <= {IDX_W{1'b0}};
            we_lat_q    <= 1'b0;
            addr_lat_q  <= {ADDR_W{1'b0}};
            wdata_lat_q <= {DATA_W{1'b0}};
            lat_cnt_q   <= {LAT_W{1'b0}};
            gnt_q       <= {NCORES{1'b0}};
            done_q      <= {NCORES{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q    <= {IDX_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_lat_q    <= we_lat_d;
            addr_lat_q  <= addr_lat_d;
            wdata_lat_q <= wdata_lat_d;
            lat_cnt_q   <= lat_cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed self-checking bench for shared_mem_arbiter (NCORES=4, MEM_LAT=2).
// Memory model returns (address ^ 8'h46), valid on the MEM_LAT-th edge after it samples mem_en.
module tb_shared_mem_arbiter;

    localparam int NC  = 4;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          resetARB;
    logic [3:0]    req, we;
    logic [31:0]   addr, wdata;
    logic [3:0]    gnt, done;
    logic [7:0]    rdata, mem_addr, mem_wdata, mem_rdata;
    logic          busy, mem_en, mem_we;

    logic [LAT-1:0] rd_pipe = '0;
    logic [7:0]     rd_addr = 8'h00;

    int n_pass  = 0;
    int n_total = 0;

    int  grants[$];
    int  done_cnt[NC];
    int  multi_gnt;
    bit  finished;

    shared_mem_arbiter #(.NCORES(NC), .ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT)) dut (
        .clk(clk), .resetARB(resetARB), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model with MEM_LAT-edge read latency.
    always @(posedge clk) begin
        rd_pipe <= {rd_pipe[LAT-2:0], (mem_en && !mem_we)};
        if (mem_en && !mem_we) rd_addr <= mem_addr;
    end
    assign mem_rdata = rd_pipe[LAT-1] ? (rd_addr ^ 8'h46) : 8'hEE;

    // Drives req under mask, records grant order, done pulses and overlapping grants.
    task automatic run_arb(input logic [3:0] mask, input bit drop_on_done, input int ngrants);
        logic [3:0] prev;
        grants.delete();
        for (int i = 0; i < NC; i++) done_cnt[i] = 0;
        multi_gnt = 0;
        finished  = 1'b0;
        prev      = 4'b0000;
        @(negedge clk);
        we  = 4'b0000;
        req = mask;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if ($countones(gnt) > 1) multi_gnt++;
            if (gnt != 4'b0000 && prev == 4'b0000) begin
                for (int i = 0; i < NC; i++) if (gnt[i]) grants.push_back(i);
            end
            prev = gnt;
            for (int i = 0; i < NC; i++) begin
                if (done[i]) begin
                    done_cnt[i]++;
                    if (drop_on_done) req[i] = 1'b0;
                end
            end
            if (!drop_on_done && grants.size() >= ngrants) req = 4'b0000;
            if (req == 4'b0000 && !busy) begin
                finished = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetARB = 1'b1; req = 4'b0000; we = 4'b0000; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if ({gnt, done, busy, mem_en, mem_we} !== 11'b0) $display("FAIL reset_ctl: got %b want 0", {gnt, done, busy, mem_en, mem_we}); else n_pass++;
        n_total++; if ({rdata, mem_addr, mem_wdata} !== 24'h0) $display("FAIL reset_data: got %h want 0", {rdata, mem_addr, mem_wdata}); else n_pass++;
        @(negedge clk); resetARB = 1'b0;
        @(posedge clk); #1;
        n_total++; if ({gnt, busy, mem_en} !== 6'b0) $display("FAIL idle_noreq: got %b want 0", {gnt, busy, mem_en}); else n_pass++;
    endtask

    task automatic test_read();
        @(negedge clk); we = 4'b0000; addr[16 +: 8] = 8'h1A; req = 4'b0100;
        @(posedge clk); #1;
        n_total++; if (gnt !== 4'b0100) $display("FAIL read_gnt: got %b want 0100", gnt); else n_pass++;
        n_total++; if (busy !== 1'b1 || mem_en !== 1'b0) $display("FAIL read_busy: got busy=%b en=%b want 1 0", busy, mem_en); else n_pass++;
        addr[16 +: 8] = 8'h77;
        @(posedge clk); #1;
        n_total++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h1A}) $display("FAIL read_issue: got en=%b we=%b a=%h want 1 0 1a", mem_en, mem_we, mem_addr); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (mem_en !== 1'b0) $display("FAIL read_en_pulse: got %b want 0", mem_en); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (done !== 4'b0000) $display("FAIL read_done_early: got %b want 0000", done); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (done !== 4'b0100 || gnt !== 4'b0000) $display("FAIL read_done: got done=%b gnt=%b want 0100 0000", done, gnt); else n_pass++;
        n_total++; if (rdata !== 8'h5C) $display("FAIL read_rdata: got %h want 5c", rdata); else n_pass++;
        req = 4'b0000;
        @(posedge clk); #1;
        n_total++; if (done !== 4'b0000 || busy !== 1'b0) $display("FAIL read_resp: got done=%b busy=%b want 0000 0", done, busy); else n_pass++;
    endtask

    task automatic test_write();
        @(negedge clk); we = 4'b0001; addr[0 +: 8] = 8'h03; wdata[0 +: 8] = 8'hA5; req = 4'b0001;
        @(posedge clk); #1;
        n_total++; if (gnt !== 4'b0001) $display("FAIL write_gnt: got %b want 0001", gnt); else n_pass++;
        wdata[0 +: 8] = 8'h11;
        @(posedge clk); #1;
        n_total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h03, 8'hA5}) $display("FAIL write_issue: got en=%b we=%b a=%h d=%h want 1 1 03 a5", mem_en, mem_we, mem_addr, mem_wdata); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({mem_en, mem_we} !== 2'b00) $display("FAIL write_en_pulse: got %b want 00", {mem_en, mem_we}); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (done !== 4'b0001) $display("FAIL write_done: got %b want 0001", done); else n_pass++;
        n_total++; if (rdata !== 8'h5C) $display("FAIL write_rdata_kept: got %h want 5c", rdata); else n_pass++;
        req = 4'b0000; we = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_all_requests();
        @(negedge clk); resetARB = 1'b1;
        @(negedge clk); resetARB = 1'b0;
        run_arb(4'b1111, 1'b1, 4);
        n_total++; if (!finished) $display("FAIL all_timeout: got unfinished want finished"); else n_pass++;
        n_total++; if (grants.size() !== 4) $display("FAIL all_ngrants: got %0d want 4", grants.size()); else n_pass++;
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            n_total++; if (grants[i] !== i) $display("FAIL all_order[%0d]: got %0d want %0d", i, grants[i], i); else n_pass++;
        end
        for (int i = 0; i < NC; i++) begin
            n_total++; if (done_cnt[i] !== 1) $display("FAIL all_done[%0d]: got %0d want 1", i, done_cnt[i]); else n_pass++;
        end
        n_total++; if (multi_gnt !== 0) $display("FAIL all_onehot: got %0d overlaps want 0", multi_gnt); else n_pass++;
    endtask

    task automatic test_fairness();
        int exp_order[6];
`ifdef ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0, 0};
`else
        exp_order = '{0, 3, 0, 3, 0, 3};
`endif
        run_arb(4'b1001, 1'b0, 6);
        n_total++; if (!finished || grants.size() !== 6) $display("FAIL fair_count: got %0d grants want 6", grants.size()); else n_pass++;
        for (int i = 0; i < 6 && i < grants.size(); i++) begin
            n_total++; if (grants[i] !== exp_order[i]) $display("FAIL fair_order[%0d]: got %0d want %0d", i, grants[i], exp_order[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); we = 4'b0000; addr[8 +: 8] = 8'h40; req = 4'b0010;
        @(posedge clk); #1;
        n_total++; if (gnt !== 4'b0010) $display("FAIL rst_pre_gnt: got %b want 0010", gnt); else n_pass++;
        @(posedge clk); #1;
        resetARB = 1'b1;
        #1;
        n_total++; if ({gnt, done, busy, mem_en, mem_we} !== 11'b0) $display("FAIL rst_async: got %b want 0", {gnt, done, busy, mem_en, mem_we}); else n_pass++;
        repeat (3) begin
            @(negedge clk);
            n_total++; if (done !== 4'b0000) $display("FAIL rst_no_done: got %b want 0000", done); else n_pass++;
        end
        resetARB = 1'b0;
        @(posedge clk); #1;
        n_total++; if (gnt !== 4'b0010) $display("FAIL rst_regnt: got %b want 0010", gnt); else n_pass++;
        repeat (4) @(posedge clk);
        #1;
        n_total++; if (done !== 4'b0010 || rdata !== 8'h06) $display("FAIL rst_serve: got done=%b rdata=%h want 0010 06", done, rdata); else n_pass++;
        req = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_prio();
        int exp_order[3];
`ifdef ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0};
`else
        exp_order = '{0, 3, 0};
`endif
        @(negedge clk); resetARB = 1'b1;
        @(negedge clk); resetARB = 1'b0;
        run_arb(4'b1001, 1'b0, 3);
        n_total++; if (!finished || grants.size() !== 3) $display("FAIL prio_count: got %0d grants want 3", grants.size()); else n_pass++;
        for (int i = 0; i < 3 && i < grants.size(); i++) begin
            n_total++; if (grants[i] !== exp_order[i]) $display("FAIL prio_order[%0d]: got %0d want %0d", i, grants[i], exp_order[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_all_requests();
        test_fairness();
        test_reset_mid();
        test_fixed_prio();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
